race_lap_referee: RTL and testbench

//  - N-car race referee: start countdown, per-car checkpoint-ordered lap counting, finish and winner detection.
//  - Sits between the map/collision logic (checkpoint hits) and the status-bar renderer (lap and countdown digits).
//  - Generalises the fixed 2-car, LAP_MAX=3 scheme: car count, lap target, checkpoint count and countdown are parameters.
//  - A lap counts only after every checkpoint is passed in order.

---
 rtl/race_lap_referee.sv | 231 +++++++++++++++++++++++
 tb/tb_race_lap_referee.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_lap_referee.sv
// race_lap_referee
//   N-car race referee. It runs a start countdown, counts laps per car with
//   checkpoints taken in order, and detects finishers and the winner.
//   Checkpoint hits come from the map/collision logic. Lap and countdown
//   digits go to the status-bar renderer.
//
//   Optional feature (define the macro to enable it): RACE_FULL_RANKING_EN
//     - Adds the o_rank port, which gives the finish order of each car.
//     - The race keeps running until every car has finished.
//
//   Ports
//     i_clk, i_rst      clock; synchronous active-high reset
//     i_start           start/restart pulse (honoured in IDLE and FINISH)
//     i_frame_tick      one pulse per video frame (drives the countdown)
//     i_cp_valid/i_cp_id  per-car checkpoint hit and checkpoint index
//     o_state           0 IDLE, 1 COUNTDOWN, 2 RACE, 3 FINISH
//     o_race_en         high only in RACE
//     o_countdown       seconds left (BCD digit), 0 outside COUNTDOWN
//     o_lap/o_lap_pulse completed laps per car / one-cycle lap strobe
//     o_finished        sticky per-car finish flags
//     o_winner(_valid)  first car to finish (lowest index on a tie)
//     o_rank            finish order per car (ranking build only)

// Per-car lap tracker: in-order checkpoint sequencing and the lap count.
module race_car_lap #(
  parameter int NUM_CP  = 4,
  parameter int LAP_MAX = 3,
  parameter int CP_W    = 2,
  parameter int DIG_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_active,
  input  logic             i_cp_valid,
  input  logic [CP_W-1:0]  i_cp_id,
  output logic [DIG_W-1:0] o_lap,
  output logic             o_lap_pulse,
  output logic             o_finished,
  output logic             o_fin_rise
);
  logic [CP_W-1:0] next_cp;
  logic            hit, lap_hit;

  // Only the expected checkpoint counts. Reverse driving, skipped
  // checkpoints and repeated checkpoints simply do not match.
  assign hit        = i_active && i_cp_valid && !o_finished && (i_cp_id == next_cp);
  assign lap_hit    = hit && (i_cp_id == '0);
  assign o_fin_rise = lap_hit && (o_lap == DIG_W'(LAP_MAX - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      next_cp     <= CP_W'(1);
      o_lap       <= '0;
      o_lap_pulse <= 1'b0;
      o_finished  <= 1'b0;
    end else begin
      o_lap_pulse <= 1'b0;
      if (i_clear) begin
        next_cp    <= CP_W'(1);
        o_lap      <= '0;
        o_finished <= 1'b0;
      end else if (hit) begin
        next_cp <= (next_cp == CP_W'(NUM_CP - 1)) ? '0 : next_cp + CP_W'(1);
        if (lap_hit) begin
          o_lap       <= o_lap + DIG_W'(1);
          o_lap_pulse <= 1'b1;
        end
        if (o_fin_rise) o_finished <= 1'b1;
      end
    end
  end
endmodule

module race_lap_referee #(
  parameter int NUM_CARS       = 2,
  parameter int NUM_CP         = 4,
  parameter int LAP_MAX        = 3,
  parameter int FRAMES_PER_SEC = 60,
  parameter int COUNTDOWN_SEC  = 3,
  localparam int CP_W  = $clog2(NUM_CP),
  localparam int ID_W  = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1,
  localparam int DIG_W = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_frame_tick,
  input  logic [NUM_CARS-1:0]       i_cp_valid,
  input  logic [NUM_CARS*CP_W-1:0]  i_cp_id,
  output logic [1:0]                o_state,
  output logic                      o_race_en,
  output logic [DIG_W-1:0]          o_countdown,
  output logic [NUM_CARS*DIG_W-1:0] o_lap,
  output logic [NUM_CARS-1:0]       o_lap_pulse,
  output logic [NUM_CARS-1:0]       o_finished,
  output logic [ID_W-1:0]           o_winner,
  output logic                      o_winner_valid
`ifdef RACE_FULL_RANKING_EN
  ,
  output logic [NUM_CARS*ID_W-1:0]  o_rank
`endif
);
  localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COUNTDOWN = 2'd1, S_RACE = 2'd2, S_FINISH = 2'd3} state_t;

  state_t                              state, state_nxt;
  logic [FC_W-1:0]                     fcnt;
  logic                                race_clear, race_active, sec_wrap;
  logic [NUM_CARS-1:0][CP_W-1:0]       cp_id_arr;
  logic [NUM_CARS-1:0][DIG_W-1:0]      lap_arr;
  logic [NUM_CARS-1:0]                 finished, fin_rise;
  logic [ID_W-1:0]                     first_idx;

  assign cp_id_arr  = i_cp_id;
  assign o_lap      = lap_arr;
  assign o_finished = finished;
  assign o_state    = state;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (i_start) state_nxt = S_COUNTDOWN;
      S_COUNTDOWN: if (sec_wrap && o_countdown == DIG_W'(1)) state_nxt = S_RACE;
`ifdef RACE_FULL_RANKING_EN
      S_RACE:      if (&finished) state_nxt = S_FINISH;
`else
      // Leaves one cycle after the first finisher; the finished flag is registered.
      S_RACE:      if (|finished) state_nxt = S_FINISH;
`endif
      S_FINISH:    if (i_start) state_nxt = S_COUNTDOWN;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Control strobes decoded from the state
  always_comb begin
    race_clear  = ((state == S_IDLE) || (state == S_FINISH)) && i_start;
    race_active = (state == S_RACE);
    sec_wrap    = (state == S_COUNTDOWN) && i_frame_tick && (fcnt == FC_W'(FRAMES_PER_SEC - 1));
  end

  for (genvar k = 0; k < NUM_CARS; k++) begin : g_car
    race_car_lap #(.NUM_CP(NUM_CP), .LAP_MAX(LAP_MAX), .CP_W(CP_W), .DIG_W(DIG_W)) u_car (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clear     (race_clear),
      .i_active    (race_active),
      .i_cp_valid  (i_cp_valid[k]),
      .i_cp_id     (cp_id_arr[k]),
      .o_lap       (lap_arr[k]),
      .o_lap_pulse (o_lap_pulse[k]),
      .o_finished  (finished[k]),
      .o_fin_rise  (fin_rise[k])
    );
  end

  // Lowest-index finisher in this cycle (tie break)
  always_comb begin
    first_idx = '0;
    for (int k = NUM_CARS - 1; k >= 0; k--)
      if (fin_rise[k]) first_idx = ID_W'(k);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fcnt           <= '0;
      o_countdown    <= '0;
      o_race_en      <= 1'b0;
      o_winner       <= '0;
      o_winner_valid <= 1'b0;
    end else begin
      o_race_en <= (state_nxt == S_RACE);
      if (race_clear) begin
        fcnt           <= '0;
        o_countdown    <= DIG_W'(COUNTDOWN_SEC);
        o_winner       <= '0;
        o_winner_valid <= 1'b0;
      end else begin
        if ((state == S_COUNTDOWN) && i_frame_tick) begin
          // Reaches 0 exactly on the final wrap, the same edge that enters RACE.
          if (sec_wrap) begin
            fcnt        <= '0;
            o_countdown <= o_countdown - DIG_W'(1);
          end else begin
            fcnt <= fcnt + FC_W'(1);
          end
        end
        if (race_active && !o_winner_valid && |fin_rise) begin
          o_winner       <= first_idx;
          o_winner_valid <= 1'b1;
        end
      end
    end
  end

`ifdef RACE_FULL_RANKING_EN
  logic [NUM_CARS-1:0][ID_W-1:0] rank_q, rank_nxt;

  // Cars already finished take the earlier ranks. Cars that finish together
  // take the following ranks, lower index first.
  always_comb begin
    int unsigned base;
    base     = 0;
    rank_nxt = rank_q;
    for (int k = 0; k < NUM_CARS; k++) base = base + 32'(finished[k]);
    for (int k = 0; k < NUM_CARS; k++) begin
      if (fin_rise[k]) begin
        rank_nxt[k] = ID_W'(base);
        base        = base + 1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)           rank_q <= '0;
    else if (race_clear) rank_q <= '0;
    else                 rank_q <= rank_nxt;
  end

  assign o_rank = rank_q;
`endif
endmodule

// File: tb/tb_race_lap_referee.sv
// Self-checking bench for race_lap_referee (default parameters). A
// tick-counting, lap-counting reference model runs alongside the DUT, and the
// scenario tasks check it against the DUT. Extra checks run when
// RACE_FULL_RANKING_EN is defined.
module tb_race_lap_referee;
  localparam int NUM_CARS = 2, NUM_CP = 4, LAP_MAX = 3, FPS = 60, CD_SEC = 3;
  localparam int CP_W = 2, ID_W = 1;

  logic clk = 1'b0;
  logic rst, start, tick;
  logic [NUM_CARS-1:0]      cp_valid;
  logic [NUM_CARS*CP_W-1:0] cp_id;
  logic [1:0]               state;
  logic                     race_en;
  logic [3:0]               countdown;
  logic [NUM_CARS*4-1:0]    lap;
  logic [NUM_CARS-1:0]      lap_pulse, finished;
  logic [ID_W-1:0]          winner;
  logic                     winner_valid;
`ifdef RACE_FULL_RANKING_EN
  logic [NUM_CARS*ID_W-1:0] rank;
`endif

  int vectors = 0, errors = 0;

  // Reference model state
  int m_state, m_cd, m_ticks, m_win, m_nfin;
  bit m_wv, m_en;
  int m_lap [NUM_CARS], m_next [NUM_CARS], m_rank [NUM_CARS];
  bit m_fin [NUM_CARS], m_pulse [NUM_CARS];

  always #5 clk = ~clk;

  race_lap_referee dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_frame_tick(tick),
    .i_cp_valid(cp_valid), .i_cp_id(cp_id),
    .o_state(state), .o_race_en(race_en), .o_countdown(countdown),
    .o_lap(lap), .o_lap_pulse(lap_pulse), .o_finished(finished),
    .o_winner(winner), .o_winner_valid(winner_valid)
`ifdef RACE_FULL_RANKING_EN
    , .o_rank(rank)
`endif
  );

  task automatic model_clear();
    m_win = 0; m_wv = 0; m_nfin = 0;
    for (int k = 0; k < NUM_CARS; k++) begin
      m_lap[k] = 0; m_next[k] = 1; m_fin[k] = 0; m_rank[k] = 0;
    end
  endtask

  // One clock of the race rules, evaluated with the inputs currently applied.
  task automatic model_step();
    int ns, id;
    bit prev_any, prev_all;
    bit rise [NUM_CARS];
    for (int k = 0; k < NUM_CARS; k++) m_pulse[k] = 0;
    if (rst) begin
      m_state = 0; m_cd = 0; m_ticks = 0; m_en = 0;
      model_clear();
      return;
    end
    ns = m_state;
    prev_any = 0; prev_all = 1;
    for (int k = 0; k < NUM_CARS; k++) begin
      prev_any |= m_fin[k]; prev_all &= m_fin[k];
    end
    case (m_state)
      0, 3: if (start) begin
        ns = 1; m_cd = CD_SEC; m_ticks = 0;
        model_clear();
      end
      1: if (tick) begin
        m_ticks++;
        if (m_ticks == CD_SEC * FPS) begin ns = 2; m_cd = 0; end
        else m_cd = CD_SEC - m_ticks / FPS;
      end
      default: begin
        for (int k = 0; k < NUM_CARS; k++) begin
          rise[k] = 0;
          id = int'(cp_id[k*CP_W +: CP_W]);
          if (cp_valid[k] && !m_fin[k] && id == m_next[k]) begin
            m_next[k] = (m_next[k] + 1) % NUM_CP;
            if (id == 0) begin
              m_lap[k]++; m_pulse[k] = 1;
              if (m_lap[k] == LAP_MAX) begin m_fin[k] = 1; rise[k] = 1; end
            end
          end
        end
        for (int k = 0; k < NUM_CARS; k++) if (rise[k]) begin
          if (!m_wv) begin m_win = k; m_wv = 1; end
          m_rank[k] = m_nfin; m_nfin++;
        end
`ifdef RACE_FULL_RANKING_EN
        if (prev_all) ns = 3;
`else
        if (prev_any) ns = 3;
`endif
      end
    endcase
    m_en = (ns == 2);
    m_state = ns;
  endtask

  function automatic logic [NUM_CARS*4-1:0] exp_lap();
    logic [NUM_CARS*4-1:0] v = '0;
    for (int k = 0; k < NUM_CARS; k++) v[k*4 +: 4] = 4'(m_lap[k]);
    return v;
  endfunction

  function automatic logic [NUM_CARS-1:0] exp_fin();
    logic [NUM_CARS-1:0] v = '0;
    for (int k = 0; k < NUM_CARS; k++) v[k] = m_fin[k];
    return v;
  endfunction

  function automatic logic [NUM_CARS-1:0] exp_pulse();
    logic [NUM_CARS-1:0] v = '0;
    for (int k = 0; k < NUM_CARS; k++) v[k] = m_pulse[k];
    return v;
  endfunction

  function automatic logic [NUM_CARS*ID_W-1:0] exp_rank();
    logic [NUM_CARS*ID_W-1:0] v = '0;
    for (int k = 0; k < NUM_CARS; k++) v[k*ID_W +: ID_W] = ID_W'(m_rank[k]);
    return v;
  endfunction

  task automatic step();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    start = 0; tick = 0; cp_valid = '0; cp_id = '0;
  endtask

  task automatic set_car(input int k, input bit v, input int id);
    cp_valid[k] = v;
    cp_id[k*CP_W +: CP_W] = CP_W'(id);
  endtask

  task automatic run_countdown();
    start = 1; step(); start = 0;
    tick = 1; repeat (CD_SEC * FPS) step(); tick = 0;
  endtask

  // Drive n full legal laps (1,2,3,0) for every car selected in mask.
  task automatic drive_laps(input logic [NUM_CARS-1:0] mask, input int n);
    int seq [4] = '{1, 2, 3, 0};
    for (int l = 0; l < n; l++)
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < NUM_CARS; k++) set_car(k, mask[k], seq[i]);
        step();
      end
    cp_valid = '0;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1; step(); step(); rst = 0;
    vectors++;
    if (state !== 2'd0 || race_en !== 1'b0 || countdown !== 4'd0) begin
      errors++; $display("FAIL reset_ctrl: state=%0d en=%0b cd=%0d, want 0/0/0", state, race_en, countdown);
    end
    vectors++;
    if (lap !== '0 || lap_pulse !== '0 || finished !== '0 || winner !== '0 || winner_valid !== 1'b0) begin
      errors++; $display("FAIL reset_race: lap=%h pulse=%b fin=%b win=%0d wv=%0b, want all 0",
                         lap, lap_pulse, finished, winner, winner_valid);
    end
  endtask

  task automatic test_countdown();
    start = 1; step(); start = 0;
    vectors++;
    if (state !== 2'd1 || countdown !== 4'd3) begin
      errors++; $display("FAIL cd_load: state=%0d cd=%0d, want 1/3", state, countdown);
    end
    // Random tick gaps; start and checkpoint activity must be ignored.
    for (int c = 0; c < 3000 && m_state == 1; c++) begin
      tick = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
      cp_valid = NUM_CARS'($urandom); cp_id = (NUM_CARS*CP_W)'($urandom);
      step();
      vectors++;
      if (state !== 2'(m_state) || countdown !== 4'(m_cd) || race_en !== m_en || lap !== '0) begin
        errors++; $display("FAIL countdown: tick#%0d state=%0d cd=%0d en=%0b lap=%h, want %0d/%0d/%0b/0",
                           m_ticks, state, countdown, race_en, lap, m_state, m_cd, m_en);
      end
    end
    idle_inputs();
    vectors++;
    if (state !== 2'd2 || race_en !== 1'b1) begin
      errors++; $display("FAIL cd_to_race: state=%0d en=%0b, want 2/1", state, race_en);
    end
  endtask

  task automatic test_legal_lap();
    int seq [4] = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      set_car(0, 1, seq[i]); step();
      vectors++;
      if (lap !== exp_lap() || lap_pulse !== exp_pulse()) begin
        errors++; $display("FAIL legal_seq: cp=%0d lap=%h pulse=%b, want %h/%b", seq[i], lap, lap_pulse, exp_lap(), exp_pulse());
      end
    end
    vectors++;
    if (lap[3:0] !== 4'd1 || lap_pulse[0] !== 1'b1) begin
      errors++; $display("FAIL legal_lap: lap0=%0d pulse0=%b, want 1/1", lap[3:0], lap_pulse[0]);
    end
    set_car(0, 0, 0); step();
    vectors++;
    if (lap_pulse[0] !== 1'b0) begin
      errors++; $display("FAIL pulse_width: pulse0=%b, want 0", lap_pulse[0]);
    end
    set_car(0, 1, 0); step(); set_car(0, 0, 0); step();
    vectors++;
    if (lap[3:0] !== 4'd1 || lap_pulse[0] !== 1'b0) begin
      errors++; $display("FAIL repeat_cp0: lap0=%0d pulse0=%b, want 1/0", lap[3:0], lap_pulse[0]);
    end
  endtask

  task automatic test_illegal_order();
    int seq [6] = '{3, 2, 1, 0, 2, 0};
    for (int i = 0; i < 6; i++) begin
      set_car(1, 1, seq[i]); step();
      vectors++;
      if (lap[7:4] !== 4'd0 || lap_pulse[1] !== 1'b0) begin
        errors++; $display("FAIL illegal_order: cp=%0d lap1=%0d pulse1=%b, want 0/0", seq[i], lap[7:4], lap_pulse[1]);
      end
    end
    cp_valid = '0;
  endtask

  task automatic test_random_race();
    int extra = 0;
    int r;
    for (int c = 0; c < 4000 && extra < 3; c++) begin
      for (int k = 0; k < NUM_CARS; k++) begin
        r = $urandom_range(0, 3);
        if (r == 0) set_car(k, 0, 0);
        else set_car(k, 1, (r <= 2) ? m_next[k] : $urandom_range(0, NUM_CP - 1));
      end
      start = (m_state == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (m_state == 3) extra++;
      step();
      vectors++;
      if (state !== 2'(m_state) || race_en !== m_en || lap !== exp_lap() || lap_pulse !== exp_pulse() ||
          finished !== exp_fin() || winner_valid !== m_wv || winner !== ID_W'(m_win)) begin
        errors++; $display("FAIL random_race: st=%0d en=%0b lap=%h p=%b fin=%b w=%0d/%0b, want %0d/%0b/%h/%b/%b/%0d/%0b",
                           state, race_en, lap, lap_pulse, finished, winner, winner_valid,
                           m_state, m_en, exp_lap(), exp_pulse(), exp_fin(), m_win, m_wv);
      end
`ifdef RACE_FULL_RANKING_EN
      vectors++;
      if (rank !== exp_rank()) begin
        errors++; $display("FAIL random_rank: rank=%b, want %b", rank, exp_rank());
      end
`endif
    end
    idle_inputs();
    vectors++;
    if (state !== 2'd3) begin
      errors++; $display("FAIL race_timeout: state=%0d, want 3", state);
    end
  endtask

  task automatic test_tie();
    start = 1; step(); start = 0;
    vectors++;
    if (state !== 2'd1 || lap !== '0 || finished !== '0 || winner_valid !== 1'b0) begin
      errors++; $display("FAIL restart_clear: st=%0d lap=%h fin=%b wv=%0b, want 1/0/0/0", state, lap, finished, winner_valid);
    end
    tick = 1; repeat (CD_SEC * FPS) step(); tick = 0;
    drive_laps(2'b11, LAP_MAX);
    vectors++;
    if (finished !== 2'b11 || winner !== 1'b0 || winner_valid !== 1'b1 || state !== 2'd2 || lap !== 8'h33) begin
      errors++; $display("FAIL tie_finish: fin=%b win=%0d wv=%0b st=%0d lap=%h, want 11/0/1/2/33",
                         finished, winner, winner_valid, state, lap);
    end
    step();
    vectors++;
    if (state !== 2'd3 || race_en !== 1'b0 || lap !== 8'h33 || winner_valid !== 1'b1) begin
      errors++; $display("FAIL tie_state: st=%0d en=%0b lap=%h wv=%0b, want 3/0/33/1", state, race_en, lap, winner_valid);
    end
  endtask

  task automatic test_reset_mid_race();
    // Reset in the middle of the countdown.
    start = 1; step(); start = 0; tick = 1; repeat (70) step(); tick = 0;
    rst = 1; step(); rst = 0;
    vectors++;
    if (state !== 2'd0 || countdown !== 4'd0 || race_en !== 1'b0) begin
      errors++; $display("FAIL rst_countdown: st=%0d cd=%0d en=%0b, want 0/0/0", state, countdown, race_en);
    end
    run_countdown();
    drive_laps(2'b01, 2);
    vectors++;
    if (lap[3:0] !== 4'd2 || state !== 2'd2) begin
      errors++; $display("FAIL pre_reset: lap0=%0d st=%0d, want 2/2", lap[3:0], state);
    end
    start = 1; step(); start = 0;
    vectors++;
    if (state !== 2'd2 || countdown !== 4'd0) begin
      errors++; $display("FAIL start_in_race: st=%0d cd=%0d, want 2/0", state, countdown);
    end
    rst = 1; step(); rst = 0;
    vectors++;
    if (state !== 2'd0 || race_en !== 1'b0 || countdown !== 4'd0 || lap !== '0 || lap_pulse !== '0 ||
        finished !== '0 || winner !== '0 || winner_valid !== 1'b0) begin
      errors++; $display("FAIL rst_race: st=%0d en=%0b cd=%0d lap=%h p=%b fin=%b w=%0d wv=%0b, want all 0",
                         state, race_en, countdown, lap, lap_pulse, finished, winner, winner_valid);
    end
  endtask

`ifdef RACE_FULL_RANKING_EN
  task automatic test_ranking();
    run_countdown();
    drive_laps(2'b10, LAP_MAX);
    step();
    vectors++;
    if (finished !== 2'b10 || winner !== 1'b1 || winner_valid !== 1'b1 || state !== 2'd2 || rank[1] !== 1'b0) begin
      errors++; $display("FAIL rank_first: fin=%b w=%0d wv=%0b st=%0d rank=%b, want 10/1/1/2/x0",
                         finished, winner, winner_valid, state, rank);
    end
    drive_laps(2'b01, LAP_MAX);
    vectors++;
    if (finished !== 2'b11 || state !== 2'd2 || rank !== 2'b01) begin
      errors++; $display("FAIL rank_second: fin=%b st=%0d rank=%b, want 11/2/01", finished, state, rank);
    end
    step();
    vectors++;
    if (state !== 2'd3 || winner !== 1'b1 || rank !== 2'b01) begin
      errors++; $display("FAIL rank_finish: st=%0d w=%0d rank=%b, want 3/1/01", state, winner, rank);
    end
  endtask
`endif

  initial begin
    idle_inputs(); rst = 1;
    test_reset();
    test_countdown();
    test_legal_lap();
    test_illegal_order();
    test_random_race();
    test_tie();
    test_reset_mid_race();
`ifdef RACE_FULL_RANKING_EN
    test_ranking();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
